// File: rtl/mem_bus_scheduler.sv
//------------------------------------------------------------------------------
// mem_bus_scheduler
//
// Shares one external memory bus between instruction fetch (port 0) and the
// load/store unit (port 1). At most one transaction is outstanding. Port 1
// wins arbitration unless port 0 has waited through STARVE_LIMIT consecutive
// port-1 grants. A flush during a fetch drains the bus transaction and drops
// its response. A bus transaction that does not complete within
// TIMEOUT_CYCLES is abandoned, and timeout_err pulses.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   req0_valid/addr_p0  fetch request, held until grant0
//   grant0              one-cycle pulse, fetch accepted
//   rsp0_valid/data_p0  one-cycle pulse with fetch read data
//   req1_valid/addr_p1/we_p1/data_p1_wrt
//                       LSU request (load or store), held until grant1
//   grant1              one-cycle pulse, LSU request accepted
//   rsp1_valid/data_p1_rd
//                       one-cycle pulse, load data or store completion
//   system_flush        pipeline flush: drops an in-flight fetch response
//   system_stall        blocks new fetch grants
//   req_valid/addr/we/wrt_data
//                       bus request, held until data_valid
//   rd_data/data_valid  bus read data and one-cycle completion pulse
//   busy                a transaction is in flight
//   timeout_err         one-cycle pulse when a bus transaction times out
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_bus_scheduler #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    // port 0: instruction fetch
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] addr_p0,
    output logic                  grant0,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] data_p0,
    // port 1: load/store unit
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] addr_p1,
    input  logic                  we_p1,
    input  logic [DATA_WIDTH-1:0] data_p1_wrt,
    output logic                  grant1,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] data_p1_rd,
    // pipeline control
    input  logic                  system_flush,
    input  logic                  system_stall,
    // external memory bus
    output logic                  req_valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  we,
    output logic [DATA_WIDTH-1:0] wrt_data,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  data_valid,
    // status
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY0  = 2'd1;
    localparam logic [1:0] S_BUSY1  = 2'd2;
    localparam logic [1:0] S_DRAIN0 = 2'd3;

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic          TMO_EN     = (TIMEOUT_CYCLES > 0);
    // The counter value seen in the last cycle before the limit is reached;
    // the abandon decision is registered at the end of that cycle.
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]            r_state;
    logic [SW-1:0]         r_starve_cnt;
    logic [TW-1:0]         r_tcnt;
    logic                  r_grant0;
    logic                  r_grant1;
    logic                  r_rsp0;
    logic                  r_rsp1;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_terr;

    logic w_elig0;
    logic w_sel0;
    logic w_sel1;
    logic w_discard;
    logic w_tmo;

    // Flush in IDLE only masks port 0 for the current cycle.
    assign w_elig0 = req0_valid & ~system_stall & ~system_flush;

    // Port 1 wins unless port 0 is eligible and has been passed over
    // STARVE_LIMIT times in a row.
    assign w_sel1 = (r_state == S_IDLE) & req1_valid &
                    (~w_elig0 | (r_starve_cnt < STARVE_MAX));
    assign w_sel0 = (r_state == S_IDLE) & ~w_sel1 & w_elig0;

    // A fetch response is dropped once the fetch has been flushed, including
    // a flush that arrives in the same cycle as its completion.
    assign w_discard = (r_state == S_DRAIN0) |
                       ((r_state == S_BUSY0) & system_flush);

    // data_valid has priority over the timeout in the limit cycle.
    assign w_tmo = TMO_EN & (r_tcnt == TLAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_tcnt   <= '0;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_rsp0   <= 1'b0;
            r_rsp1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_terr   <= 1'b0;
        end else begin
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_rsp0   <= 1'b0;
            r_rsp1   <= 1'b0;
            r_terr   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // data_valid here is spurious and deliberately ignored.
                    if (w_sel1) begin
                        r_state  <= S_BUSY1;
                        r_grant1 <= 1'b1;
                        r_req    <= 1'b1;
                        r_addr   <= addr_p1;
                        r_we     <= we_p1;
                        r_wdata  <= data_p1_wrt;
                        r_tcnt   <= '0;
                    end else if (w_sel0) begin
                        r_state  <= S_BUSY0;
                        r_grant0 <= 1'b1;
                        r_req    <= 1'b1;
                        r_addr   <= addr_p0;
                        r_we     <= 1'b0;
                        r_wdata  <= '0;
                        r_tcnt   <= '0;
                    end
                end
                default: begin
                    // BUSY0, BUSY1 and DRAIN0 share completion/timeout handling.
                    if (data_valid || w_tmo) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                        r_terr  <= ~data_valid;
                        if (!w_discard) begin
                            if (r_state == S_BUSY1) begin
                                r_rsp1   <= 1'b1;
                                r_rdata1 <= data_valid ? rd_data : '0;
                            end else begin
                                r_rsp0   <= 1'b1;
                                r_rdata0 <= data_valid ? rd_data : '0;
                            end
                        end
                    end else if ((r_state == S_BUSY0) && system_flush) begin
                        r_state <= S_DRAIN0;
                        r_tcnt  <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
            endcase
        end
    end

    // Counts consecutive port-1 acceptances that bypassed a pending fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (!req0_valid || w_sel0) begin
            r_starve_cnt <= '0;
        end else if (w_sel1 && (r_starve_cnt < STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    assign grant0      = r_grant0;
    assign grant1      = r_grant1;
    assign rsp0_valid  = r_rsp0;
    assign rsp1_valid  = r_rsp1;
    assign data_p0     = r_rdata0;
    assign data_p1_rd  = r_rdata1;
    assign req_valid   = r_req;
    assign addr        = r_addr;
    assign we          = r_we;
    assign wrt_data    = r_wdata;
    assign timeout_err = r_terr;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_scheduler.sv
`timescale 1ns/1ps

module tb_mem_bus_scheduler;

    localparam int STARVE = 4;
    localparam int TMO    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [31:0] addr_p0;
    logic        grant0;
    logic        rsp0_valid;
    logic [31:0] data_p0;
    logic        req1_valid;
    logic [31:0] addr_p1;
    logic        we_p1;
    logic [31:0] data_p1_wrt;
    logic        grant1;
    logic        rsp1_valid;
    logic [31:0] data_p1_rd;
    logic        system_flush;
    logic        system_stall;
    logic        req_valid;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wrt_data;
    logic [31:0] rd_data;
    logic        data_valid;
    logic        busy;
    logic        timeout_err;

    mem_bus_scheduler #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .STARVE_LIMIT  (STARVE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .addr_p0     (addr_p0),
        .grant0      (grant0),
        .rsp0_valid  (rsp0_valid),
        .data_p0     (data_p0),
        .req1_valid  (req1_valid),
        .addr_p1     (addr_p1),
        .we_p1       (we_p1),
        .data_p1_wrt (data_p1_wrt),
        .grant1      (grant1),
        .rsp1_valid  (rsp1_valid),
        .data_p1_rd  (data_p1_rd),
        .system_flush(system_flush),
        .system_stall(system_stall),
        .req_valid   (req_valid),
        .addr        (addr),
        .we          (we),
        .wrt_data    (wrt_data),
        .rd_data     (rd_data),
        .data_valid  (data_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Tracks which port owns the bus, whether its answer is to be dropped,
    // how long it has waited, and how often port 0 has been passed over.
    bit          m_active;
    int          m_port;
    bit          m_discard;
    int          m_wait;
    int          m_starve;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wd;
    bit          e_g0, e_g1, e_r0, e_r1, e_te, e_rv;
    logic [31:0] e_d;

    task automatic model_reset();
        m_active = 0; m_port = 0; m_discard = 0; m_wait = 0; m_starve = 0;
        m_addr = 0; m_we = 0; m_wd = 0;
        e_g0 = 0; e_g1 = 0; e_r0 = 0; e_r1 = 0; e_te = 0; e_rv = 0; e_d = 0;
    endtask

    // Consumes the inputs of the current cycle, predicts the next cycle.
    task automatic model_eval();
        bit elig0;
        bit fresh_flush;
        int pick;
        e_g0 = 0; e_g1 = 0; e_r0 = 0; e_r1 = 0; e_te = 0;
        pick = -1;
        if (!m_active) begin
            elig0 = req0_valid && !system_stall && !system_flush;
            if (req1_valid && (!elig0 || m_starve < STARVE)) pick = 1;
            else if (elig0) pick = 0;
            if (pick == 1) begin
                m_addr = addr_p1; m_we = we_p1; m_wd = data_p1_wrt; e_g1 = 1;
            end else if (pick == 0) begin
                m_addr = addr_p0; m_we = 0; m_wd = 0; e_g0 = 1;
            end
            if (pick >= 0) begin
                m_active = 1; m_port = pick; m_discard = 0; m_wait = 0;
            end
        end else begin
            fresh_flush = (m_port == 0) && system_flush && !m_discard;
            if (fresh_flush) m_discard = 1;
            if (data_valid || (TMO != 0 && m_wait + 1 == TMO)) begin
                m_active = 0;
                e_te = !data_valid;
                if (!m_discard) begin
                    e_d = data_valid ? rd_data : 32'h0;
                    if (m_port == 0) e_r0 = 1; else e_r1 = 1;
                end
            end else begin
                m_wait = fresh_flush ? 0 : m_wait + 1;
            end
        end
        if (!req0_valid || pick == 0) m_starve = 0;
        else if (pick == 1 && m_starve < STARVE) m_starve++;
        e_rv = m_active;
    endtask

    // One clock: predict, advance, compare every output with the model.
    task automatic tick();
        model_eval();
        @(posedge clk); #1;
        chk("model.grant0", grant0, e_g0);
        chk("model.grant1", grant1, e_g1);
        chk("model.rsp0_valid", rsp0_valid, e_r0);
        chk("model.rsp1_valid", rsp1_valid, e_r1);
        chk("model.req_valid", req_valid, e_rv);
        chk("model.busy", busy, e_rv);
        chk("model.timeout_err", timeout_err, e_te);
        if (e_rv) begin
            chk("model.addr", addr, m_addr);
            chk("model.we", we, m_we);
            chk("model.wrt_data", wrt_data, m_wd);
        end
        if (e_r0) chk("model.data_p0", data_p0, e_d);
        if (e_r1) chk("model.data_p1_rd", data_p1_rd, e_d);
    endtask

    task automatic idle_inputs();
        req0_valid = 0; addr_p0 = 0; req1_valid = 0; addr_p1 = 0; we_p1 = 0;
        data_p1_wrt = 0; system_flush = 0; system_stall = 0; rd_data = 0; data_valid = 0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        idle_inputs();
        while (busy && c < 20) begin
            data_valid = req_valid;
            rd_data = $urandom;
            tick();
            c++;
        end
        data_valid = 0;
        chk("drain_to_idle", busy, 0);
    endtask

    // ---------------- directed vector table ----------------
    // Inputs applied during one cycle; expected outputs are those of the next.
    typedef struct {
        logic r0; logic [31:0] a0;
        logic r1; logic [31:0] a1; logic w1; logic [31:0] d1;
        logic fl, st, dv; logic [31:0] rd;
        logic g0, g1, p0, p1, rv;
        logic [31:0] ea; logic ewe; logic [31:0] ewd; logic [31:0] ed;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic r0, input logic [31:0] a0,
                                input logic r1, input logic [31:0] a1,
                                input logic w1, input logic [31:0] d1,
                                input logic fl, input logic st, input logic dv,
                                input logic [31:0] rd,
                                input logic g0, input logic g1, input logic p0,
                                input logic p1, input logic rv,
                                input logic [31:0] ea, input logic ewe,
                                input logic [31:0] ewd, input logic [31:0] ed);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.w1 = w1; v.d1 = d1;
        v.fl = fl; v.st = st; v.dv = dv; v.rd = rd;
        v.g0 = g0; v.g1 = g1; v.p0 = p0; v.p1 = p1; v.rv = rv;
        v.ea = ea; v.ewe = ewe; v.ewd = ewd; v.ed = ed;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_g1;
        int n_rv;
        bit got0;
        bit hit;

        //   r0 a0       r1 a1        w1 d1            fl st dv rd
        //   g0 g1 p0 p1 rv  ea       ewe ewd          ed
        add(1,'h100,   0,0,         0,0,             0,0,0,0,
            1,0,0,0,1,  'h100,    0,0,             0);
        add(0,0,       0,0,         0,0,             0,0,0,0,
            0,0,0,0,1,  'h100,    0,0,             0);
        add(0,0,       0,0,         0,0,             0,0,0,0,
            0,0,0,0,1,  'h100,    0,0,             0);
        add(0,0,       0,0,         0,0,             0,0,0,0,
            0,0,0,0,1,  'h100,    0,0,             0);
        add(0,0,       0,0,         0,0,             0,0,1,'h00500093,
            0,0,1,0,0,  0,        0,0,             'h00500093);
        add(0,0,       0,0,         0,0,             0,0,0,0,
            0,0,0,0,0,  0,        0,0,             0);
        add(1,'h200,   1,'h2000,    1,'hDEADBEEF,    0,0,0,0,
            0,1,0,0,1,  'h2000,   1,'hDEADBEEF,    0);
        add(1,'h200,   0,0,         0,0,             0,0,0,0,
            0,0,0,0,1,  'h2000,   1,'hDEADBEEF,    0);
        add(1,'h200,   0,0,         0,0,             0,0,1,'h11,
            0,0,0,1,0,  0,        0,0,             'h11);
        add(1,'h200,   0,0,         0,0,             0,0,0,0,
            1,0,0,0,1,  'h200,    0,0,             0);
        add(0,0,       0,0,         0,0,             0,0,1,'h33,
            0,0,1,0,0,  0,        0,0,             'h33);
        add(1,'h240,   0,0,         0,0,             1,0,0,0,
            0,0,0,0,0,  0,        0,0,             0);
        add(1,'h240,   0,0,         0,0,             0,1,0,0,
            0,0,0,0,0,  0,        0,0,             0);
        add(1,'h240,   0,0,         0,0,             0,0,0,0,
            1,0,0,0,1,  'h240,    0,0,             0);
        add(0,0,       0,0,         0,0,             0,0,1,'h44,
            0,0,1,0,0,  0,        0,0,             'h44);
        add(0,0,       0,0,         0,0,             0,0,1,'h99,
            0,0,0,0,0,  0,        0,0,             0);
        add(0,0,       1,'h2004,    0,'h1234,        0,0,0,0,
            0,1,0,0,1,  'h2004,   0,'h1234,        0);
        add(0,0,       0,0,         0,0,             0,0,1,'h77,
            0,0,0,1,0,  0,        0,0,             'h77);
        add(0,0,       0,0,         0,0,             0,0,0,0,
            0,0,0,0,0,  0,        0,0,             0);

        // ---- reset state ----
        reset = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.req_valid", req_valid, 0);
        chk("reset.busy", busy, 0);
        chk("reset.grant0", grant0, 0);
        chk("reset.grant1", grant1, 0);
        chk("reset.addr", addr, 0);
        reset = 1;

        // ---- table vectors ----
        for (int i = 0; i < tbl.size(); i++) begin
            req0_valid = tbl[i].r0; addr_p0 = tbl[i].a0;
            req1_valid = tbl[i].r1; addr_p1 = tbl[i].a1;
            we_p1 = tbl[i].w1; data_p1_wrt = tbl[i].d1;
            system_flush = tbl[i].fl; system_stall = tbl[i].st;
            data_valid = tbl[i].dv; rd_data = tbl[i].rd;
            tick();
            chk($sformatf("tbl%0d.grant0", i), grant0, tbl[i].g0);
            chk($sformatf("tbl%0d.grant1", i), grant1, tbl[i].g1);
            chk($sformatf("tbl%0d.rsp0_valid", i), rsp0_valid, tbl[i].p0);
            chk($sformatf("tbl%0d.rsp1_valid", i), rsp1_valid, tbl[i].p1);
            chk($sformatf("tbl%0d.req_valid", i), req_valid, tbl[i].rv);
            chk($sformatf("tbl%0d.busy", i), busy, tbl[i].rv);
            chk($sformatf("tbl%0d.timeout_err", i), timeout_err, 0);
            if (tbl[i].rv) begin
                chk($sformatf("tbl%0d.addr", i), addr, tbl[i].ea);
                chk($sformatf("tbl%0d.we", i), we, tbl[i].ewe);
                chk($sformatf("tbl%0d.wrt_data", i), wrt_data, tbl[i].ewd);
            end
            if (tbl[i].p0) chk($sformatf("tbl%0d.data_p0", i), data_p0, tbl[i].ed);
            if (tbl[i].p1) chk($sformatf("tbl%0d.data_p1_rd", i), data_p1_rd, tbl[i].ed);
        end
        idle_inputs();

        // ---- starvation guard: four port-1 grants, then port 0 ----
        req0_valid = 1; addr_p0 = 'h600;
        req1_valid = 1; addr_p1 = 'h700; we_p1 = 0;
        n_g1 = 0; got0 = 0;
        for (int c = 0; c < 60 && !got0; c++) begin
            tick();
            if (grant1) n_g1++;
            if (grant0) begin
                got0 = 1;
                chk("starve.cnt_after_grant0", 32'(dut.r_starve_cnt), 0);
            end
            data_valid = req_valid;
            rd_data = 32'h1000 + c;
        end
        chk("starve.grant0_seen", got0, 1);
        chk("starve.grant1_count", n_g1, STARVE);
        drain();

        // ---- flush drain ----
        req0_valid = 1; addr_p0 = 'h300;
        tick();
        chk("flush.grant0", grant0, 1);
        req0_valid = 0;
        tick();
        system_flush = 1;
        tick();
        system_flush = 0;
        chk("flush.req_held1", req_valid, 1);
        tick();
        chk("flush.req_held2", req_valid, 1);
        tick();
        chk("flush.req_held3", req_valid, 1);
        data_valid = 1; rd_data = 'hBAD0BAD0;
        tick();
        data_valid = 0;
        chk("flush.no_rsp0", rsp0_valid, 0);
        chk("flush.req_dropped", req_valid, 0);
        chk("flush.idle", busy, 0);
        req0_valid = 1; addr_p0 = 'h304;
        tick();
        chk("flush.next_grant0", grant0, 1);
        chk("flush.next_addr", addr, 'h304);
        req0_valid = 0; data_valid = 1; rd_data = 'h55;
        tick();
        data_valid = 0;
        chk("flush.next_rsp0", rsp0_valid, 1);
        chk("flush.next_data", data_p0, 'h55);

        // ---- timeout ----
        idle_inputs();
        req1_valid = 1; addr_p1 = 'h400; we_p1 = 0;
        tick();
        chk("tmo.grant1", grant1, 1);
        req1_valid = 0;
        n_rv = 1; hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (timeout_err) begin
                hit = 1;
                chk("tmo.rsp1_with_err", rsp1_valid, 1);
                chk("tmo.data_zero", data_p1_rd, 0);
                chk("tmo.req_dropped", req_valid, 0);
            end else if (req_valid) begin
                n_rv++;
            end
        end
        chk("tmo.seen", hit, 1);
        chk("tmo.req_cycles", n_rv, TMO);

        // ---- data_valid in the limit cycle beats the timeout ----
        req1_valid = 1; addr_p1 = 'h404;
        tick();
        req1_valid = 0;
        repeat (TMO - 1) tick();
        data_valid = 1; rd_data = 'hABCD1234;
        tick();
        data_valid = 0;
        chk("tmo_race.rsp1", rsp1_valid, 1);
        chk("tmo_race.no_err", timeout_err, 0);
        chk("tmo_race.data", data_p1_rd, 'hABCD1234);

        // ---- asynchronous reset in the middle of a store ----
        req1_valid = 1; addr_p1 = 'h500; we_p1 = 1; data_p1_wrt = 'hCAFE;
        tick();
        req1_valid = 0;
        tick();
        chk("rst.busy_before", busy, 1);
        #2 reset = 0;
        #1;
        chk("rst.req_valid", req_valid, 0);
        chk("rst.addr", addr, 0);
        chk("rst.we", we, 0);
        chk("rst.wrt_data", wrt_data, 0);
        chk("rst.busy", busy, 0);
        chk("rst.data_p0", data_p0, 0);
        chk("rst.data_p1_rd", data_p1_rd, 0);
        chk("rst.rsp1_valid", rsp1_valid, 0);
        chk("rst.grant1", grant1, 0);
        chk("rst.timeout_err", timeout_err, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1;
        data_valid = 1; rd_data = 'hFFFF;
        tick();
        data_valid = 0;
        chk("rst.late_dv_no_rsp1", rsp1_valid, 0);
        chk("rst.late_dv_idle", busy, 0);
        tick();

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 1500; c++) begin
            req0_valid   = ($urandom_range(0, 99) < 50);
            addr_p0      = $urandom;
            req1_valid   = ($urandom_range(0, 99) < 40);
            addr_p1      = $urandom;
            we_p1        = $urandom_range(0, 1);
            data_p1_wrt  = $urandom;
            system_flush = ($urandom_range(0, 99) < 10);
            system_stall = ($urandom_range(0, 99) < 15);
            data_valid   = ($urandom_range(0, 99) < 20);
            rd_data      = $urandom;
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
- Shares the single external memory bus between two requesters: instruction fetch (port 0) and the execution-stage load/store unit (port 1).
- Allows one outstanding transaction at a time.
- Port 1 has priority, with a starvation guard so port 0 still gets the bus.
- Handles pipeline flush by draining an in-flight fetch and discarding its response. Detects bus timeouts.
- Sits between the fetch/execution stages and the top-level memory interface.

Parameters:
ADDR_WIDTH, 32, address width of ports and bus
DATA_WIDTH, 32, data width of ports and bus
STARVE_LIMIT, 4, consecutive port-1 grants allowed while port 0 waits
TIMEOUT_CYCLES, 64, bus cycles to wait for data_valid; 0 disables timeout

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-low
req0_valid  input  1  fetch request, held until grant0
addr_p0  input  ADDR_WIDTH  fetch address
grant0  output  1  one-cycle pulse, port-0 request accepted
rsp0_valid  output  1  one-cycle pulse, data_p0 valid
data_p0  output  DATA_WIDTH  fetch read data
req1_valid  input  1  LSU request, held until grant1
addr_p1  input  ADDR_WIDTH  LSU address
we_p1  input  1  1 = store, 0 = load
data_p1_wrt  input  DATA_WIDTH  store data
grant1  output  1  one-cycle pulse, port-1 request accepted
rsp1_valid  output  1  one-cycle pulse, load data or store completion
data_p1_rd  output  DATA_WIDTH  load read data
system_flush  input  1  pipeline flush (branch taken)
system_stall  input  1  blocks new port-0 grants
req_valid  output  1  bus request, held until data_valid
addr  output  ADDR_WIDTH  bus address
we  output  1  bus write enable
wrt_data  output  DATA_WIDTH  bus write data
rd_data  input  DATA_WIDTH  bus read data
data_valid  input  1  bus completion, one-cycle pulse
busy  output  1  FSM not in IDLE
timeout_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE; all outputs 0; starve_cnt and timeout counter 0.
  - Any in-flight transaction is abandoned; no response is issued.
- FSM states: IDLE, BUSY0, BUSY1, DRAIN0.
- IDLE arbitration, evaluated each cycle:
  - elig0 = req0_valid & ~system_stall & ~system_flush.
  - If req1_valid and (~elig0 or starve_cnt < STARVE_LIMIT): select port 1.
  - Else if elig0: select port 0.
  - Else stay in IDLE.
- Acceptance (registered, next cycle):
  - grantX=1 for one cycle; req_valid=1.
  - addr, we, wrt_data latched from the selected port. Port 0 always drives we=0, wrt_data=0.
  - FSM moves to BUSYX.
  - Latency: request sampled in cycle N → grant/req_valid in N+1.
- BUSYX:
  - req_valid, addr, we, wrt_data held stable.
  - On data_valid: next cycle rspX_valid=1, with data_pX (or data_p1_rd) = rd_data registered. req_valid=0. FSM returns to IDLE.
  - A new arbitration occurs in the IDLE cycle, so transactions are at least 1 idle cycle apart.
- Flush:
  - system_flush in BUSY0 (including the grant cycle) → DRAIN0.
  - DRAIN0 keeps req_valid until data_valid, then returns to IDLE with rsp0_valid suppressed.
  - Flush in BUSY1 has no effect; loads/stores always complete.
  - Flush in IDLE blocks port 0 for that cycle only.
- Stall: affects only new port-0 grants; in-flight transactions are unaffected.
- Starvation counter (saturating, $clog2(STARVE_LIMIT+1) bits):
  - Increments on grant1 while req0_valid=1.
  - Clears on grant0, or in any cycle req0_valid=0.
- Timeout:
  - Counter clears on entry to BUSY*/DRAIN0 and increments each cycle without data_valid.
  - When it reaches TIMEOUT_CYCLES (if nonzero): req_valid=0, timeout_err=1 pulse, FSM to IDLE.
  - From BUSYX, rspX_valid=1 in the same cycle with data=0. From DRAIN0, no response.
  - If data_valid arrives in the same cycle the limit is reached, data_valid wins and there is no error.
- data_valid in IDLE is ignored (spurious).
- busy = (state != IDLE).

Test Plan:
- Single fetch: req0_valid=1, addr_p0=0x100 at cycle 0; data_valid with rd_data=0x00500093 at cycle 4 → grant0/req_valid/addr=0x100 at cycle 1, req_valid held through 4, rsp0_valid=1 with data_p0=0x00500093 at cycle 5, busy=0 at cycle 5.
- Priority: req0 and req1 (store, addr 0x2000, data 0xDEADBEEF) both asserted in the same cycle → grant1 first, we=1, wrt_data=0xDEADBEEF; port 0 granted after rsp1_valid.
- Starvation: req0 held, req1 reasserted continuously, STARVE_LIMIT=4 → 4 grant1 pulses, then grant0, then starve_cnt=0.
- Flush drain: fetch granted, system_flush pulse 1 cycle later, data_valid 3 cycles later → req_valid held until data_valid, no rsp0_valid, next request is served normally.
- Timeout: TIMEOUT_CYCLES=8, load granted, no data_valid → req_valid drops after 8 cycles, timeout_err and rsp1_valid pulse together, data_p1_rd=0.
- Reset mid-transaction: reset=0 during BUSY1 → all outputs 0 immediately (asynchronous); after release, a late data_valid is ignored and no rsp1_valid appears.
